// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

   localparam logic [31:0] INST_NOP           = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDiscard
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_prefetch_inst_fifo.sv
// Synchronous FIFO with push/pop/flush; head entry is read combinationally from storage.
module if_prefetch_inst_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_pop;

   assign do_pop = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_i && !do_pop) begin
            count_d = count_q + 1'b1;
         end else if (!push_i && do_pop) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: owns the fetch PC, keeps one memory request in flight and buffers returned words.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int unsigned BUF_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o
);

   localparam int unsigned AW = $clog2(BUF_DEPTH);

   fetch_state_e state_q;
   logic [31:0]  fetch_pc_q;
   logic [31:0]  req_pc_q;
   logic [AW:0]  count;
   logic [AW+1:0] occupancy;
   logic         credit;
   logic         push;
   logic         pop;
   logic [63:0]  head_raw;
   fetch_entry_t head;

   // Outstanding request reserves a slot; a same-cycle pop is deliberately not credited.
   assign occupancy = {1'b0, count} + {{(AW + 1){1'b0}}, state_q == StWait};
   assign credit    = occupancy < (AW + 2)'(BUF_DEPTH);

   assign push = (state_q == StWait) && mem_rvalid_i && !jump_flag_i;
   assign pop  = inst_valid_o && !hold_flag_i;

   always_comb begin
      mem_req_o  = 1'b0;
      mem_addr_o = fetch_pc_q;
      case (state_q)
         StIdle: begin
            if (!jump_flag_i && credit) mem_req_o = 1'b1;
         end
         StWait: begin
            if (mem_rvalid_i && !jump_flag_i && credit) begin
               mem_req_o  = 1'b1;
               mem_addr_o = next_pc(req_pc_q);
            end
         end
         default: ;
      endcase
      mem_req_o = mem_req_o & rst;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_ADDR;
         req_pc_q   <= RESET_ADDR;
      end else begin
         case (state_q)
            StIdle: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_addr_i;
               end else if (credit) begin
                  req_pc_q <= fetch_pc_q;
                  state_q  <= StWait;
               end
            end
            StWait: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_addr_i;
                  state_q    <= mem_rvalid_i ? StIdle : StDiscard;
               end else if (mem_rvalid_i) begin
                  fetch_pc_q <= next_pc(req_pc_q);
                  if (credit) req_pc_q <= next_pc(req_pc_q);
                  else        state_q  <= StIdle;
               end
            end
            StDiscard: begin
               if (jump_flag_i)  fetch_pc_q <= jump_addr_i;
               if (mem_rvalid_i) state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   if_prefetch_inst_fifo #(
      .WIDTH (64),
      .DEPTH (BUF_DEPTH)
   ) u_inst_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (jump_flag_i),
      .wdata_i ({req_pc_q, mem_rdata_i}),
      .head_o  (head_raw),
      .count_o (count)
   );

   assign head         = fetch_entry_t'(head_raw);
   assign inst_valid_o = (count != '0);
   assign inst_addr_o  = inst_valid_o ? head.pc : 32'h0;
   assign inst_o       = inst_valid_o ? head.inst : INST_NOP;

endmodule
